jt900h_ifetch: RTL and testbench

//  Instruction prefetch queue between the 16-bit memory bus and the register/decode

---
 rtl/jt900h_ifetch_pkg.sv | 20 ++
 rtl/jt900h_ifetch_if.sv | 11 +
 rtl/jt900h_bytequeue.sv | 65 ++++++
 rtl/jt900h_ifetch.sv | 119 +++++++++++
 tb/tb_jt900h_ifetch.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jt900h_ifetch_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Fetch FSM encodings, default queue depth and the byte-count helper.
package jt900h_ifetch_pkg;

    localparam int QB_DEF = 8;
    localparam int AW_DEF = 24;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSRD = 2'd2,
        ST_DROP  = 2'd3
    } fetch_st_t;

    // rd_len encodes "bytes minus one"
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/jt900h_ifetch_if.sv
// 16-bit instruction memory read port: word address out, read strobe held until bus_ok.
// The master is the prefetch unit; the slave is the memory side.
interface jt900h_ifetch_if #(parameter int AW = 24);
    logic [AW-1:0] bus_addr;
    logic          bus_rd;
    logic [15:0]   bus_din;
    logic          bus_ok;

    modport master (output bus_addr, output bus_rd, input bus_din, input bus_ok);
    modport slave  (input bus_addr, input bus_rd, output bus_din, output bus_ok);
endinterface

// File: rtl/jt900h_bytequeue.sv
// QB x 8 circular byte queue: 1-2 byte push, 1-4 byte pop, 4-byte zero-filled peek (combinational).
// Next-cycle visibility of pushed bytes; no internal backpressure, the caller keeps count <= QB.
module jt900h_bytequeue
    import jt900h_ifetch_pkg::*;
#(
    parameter int QB = QB_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic                    i_push2,
    input  logic [15:0]             i_push_dat,
    input  logic                    i_pop,
    input  logic [1:0]              i_pop_len,
    output logic [$clog2(QB):0]     o_count,
    output logic [31:0]             o_peek
);

    localparam int PW = $clog2(QB);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [QB];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;

    assign w_push_n = !i_push ? CW'(0) : (i_push2 ? CW'(2) : CW'(1));
    assign w_pop_n  = i_pop ? CW'(len_bytes(i_pop_len)) : CW'(0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
            r_count  <= r_count + w_push_n - w_pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_push_dat[7:0];
            if (i_push2) begin
                r_mem[r_wr_ptr + PW'(1)] <= i_push_dat[15:8];
            end
        end
    end

    // Slots beyond the fill level read as zero so stale bytes never leak out
    for (genvar g = 0; g < 4; g++) begin : g_peek
        assign o_peek[8*g +: 8] = (CW'(g) < r_count) ? r_mem[r_rd_ptr + PW'(g)] : 8'd0;
    end

    assign o_count = r_count;

endmodule

// File: rtl/jt900h_ifetch.sv
// Prefetch queue feeding decode with up to 4 little-endian opcode bytes; bus data visible next cycle.
// Requests only when !hold and the queue can take the whole word; bus_rd is held until bus_ok.
module jt900h_ifetch
    import jt900h_ifetch_pkg::*;
#(
    parameter int QB = QB_DEF,
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              pc_ld,
    input  logic [AW-1:0]     pc_new,
    input  logic              rd,
    input  logic [1:0]        rd_len,
    output logic [31:0]       dout,
    output logic              dout_ok,
    output logic [AW-1:0]     head,
    input  logic              hold,
    jt900h_ifetch_if.master   bus
);

    localparam int CW = $clog2(QB) + 1;

    fetch_st_t     r_st;
    logic [AW-1:0] r_faddr;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_bus_addr;
    logic          r_bus_rd;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic [CW-1:0] w_need;
    logic [CW-1:0] w_rd_n;
    logic          w_req;
    logic          w_dout_ok;
    logic          w_pop;
    logic          w_push;
    logic          w_flush;
    logic [15:0]   w_push_dat;

    assign w_free    = CW'(QB) - w_count;
    assign w_need    = r_faddr[0] ? CW'(1) : CW'(2);
    assign w_req     = !hold && (w_free >= w_need);
    assign w_rd_n    = CW'(len_bytes(rd_len));
    assign w_dout_ok = (w_count >= w_rd_n);

    // A pc_ld cancels any same-cycle push or pop
    assign w_flush    = cen && pc_ld;
    assign w_pop      = cen && rd && w_dout_ok && !pc_ld;
    assign w_push     = cen && (r_st == ST_BUSRD) && bus.bus_ok && !pc_ld;
    assign w_push_dat = r_faddr[0] ? {8'd0, bus.bus_din[15:8]} : bus.bus_din;

    jt900h_bytequeue #(.QB(QB)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_push2    (!r_faddr[0]),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_pop_len  (rd_len),
        .o_count    (w_count),
        .o_peek     (dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st       <= ST_STOP;
            r_faddr    <= '0;
            r_head     <= '0;
            r_bus_addr <= '0;
            r_bus_rd   <= 1'b0;
        end else if (cen) begin
            if (w_pop) begin
                r_head <= r_head + AW'(w_rd_n);
            end
            case (r_st)
                ST_STOP: begin
                    if (pc_ld) r_st <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!pc_ld && w_req) begin
                        r_bus_addr <= {r_faddr[AW-1:1], 1'b0};
                        r_bus_rd   <= 1'b1;
                        r_st       <= ST_BUSRD;
                    end
                end
                ST_BUSRD: begin
                    if (bus.bus_ok) begin
                        r_bus_rd <= 1'b0;
                        r_st     <= ST_IDLE;
                        if (!pc_ld) r_faddr <= (r_faddr | AW'(1)) + AW'(1);
                    end else if (pc_ld) begin
                        // The bus cycle cannot be aborted; wait it out and discard the data
                        r_st <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (bus.bus_ok) begin
                        r_bus_rd <= 1'b0;
                        r_st     <= ST_IDLE;
                    end
                end
                default: r_st <= ST_STOP;
            endcase
            if (pc_ld) begin
                r_faddr <= pc_new;
                r_head  <= pc_new;
            end
        end
    end

    assign dout_ok      = w_dout_ok;
    assign head         = r_head;
    assign bus.bus_addr = r_bus_addr;
    assign bus.bus_rd   = r_bus_rd;

endmodule

// File: tb/tb_jt900h_ifetch.sv
// Directed bench for the prefetch queue: a latency-programmable memory responder
// plus a linear sequence of steps checked at the falling clock edge.
module tb_jt900h_ifetch;

    logic        clk = 1'b0;
    logic        rst, cen, pc_ld, rd, hold;
    logic [23:0] pc_new;
    logic [1:0]  rd_len;
    logic [31:0] dout;
    logic        dout_ok;
    logic [23:0] head;

    logic        mem_en;
    logic        stray;
    int          lat;
    int          checks   = 0;
    int          failures = 0;
    int          nreads;

    always #5 clk = ~clk;

    jt900h_ifetch_if bus_if ();

    jt900h_ifetch dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .pc_ld   (pc_ld),
        .pc_new  (pc_new),
        .rd      (rd),
        .rd_len  (rd_len),
        .dout    (dout),
        .dout_ok (dout_ok),
        .head    (head),
        .hold    (hold),
        .bus     (bus_if)
    );

    // Memory word at a: low byte = b+0x11, high byte = b+0x33, b = a[7:0]+a[15:8]
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        logic [7:0] b;
        b = a[7:0] + a[15:8];
        return {b + 8'h33, b + 8'h11};
    endfunction

    // Responder: bus_ok pulses for one cycle after lat cycles of bus_rd
    initial begin
        int cnt;
        cnt = 0;
        bus_if.bus_ok  = 1'b0;
        bus_if.bus_din = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.bus_ok) begin
                bus_if.bus_ok = 1'b0;
                cnt = 0;
            end else if (stray) begin
                bus_if.bus_ok  = 1'b1;
                bus_if.bus_din = 16'hBEEF;
            end else if (mem_en && bus_if.bus_rd) begin
                cnt++;
                if (cnt >= lat) begin
                    bus_if.bus_ok  = 1'b1;
                    bus_if.bus_din = mem_word(bus_if.bus_addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; pc_ld = 1'b0; rd = 1'b0; hold = 1'b0;
        pc_new = '0; rd_len = 2'd0; mem_en = 1'b1; stray = 1'b0; lat = 1;
        tick(); tick();
        chk("rst_bus_rd",   32'(bus_if.bus_rd),   32'h0);
        chk("rst_bus_addr", 32'(bus_if.bus_addr), 32'h0);
        chk("rst_head",     32'(head),            32'h0);
        chk("rst_dout",     dout,                 32'h0);
        chk("rst_dout_ok",  32'(dout_ok),         32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("stop_no_fetch", 32'(bus_if.bus_rd), 32'h0);

        // Even start address
        pc_ld = 1'b1; pc_new = 24'h000100;
        tick();
        pc_ld = 1'b0;
        chk("t1_idle_rd",  32'(bus_if.bus_rd), 32'h0);
        chk("t1_head",     32'(head),          32'h100);
        tick();
        chk("t1_bus_rd",   32'(bus_if.bus_rd),   32'h1);
        chk("t1_bus_addr", 32'(bus_if.bus_addr), 32'h100);
        tick();
        rd_len = 2'd1; #1;
        chk("t1_dout",     dout,         32'h00003412);
        chk("t1_dout_ok",  32'(dout_ok), 32'h1);

        // Odd start address: only the high byte of the first word is queued
        pc_ld = 1'b1; pc_new = 24'h000101;
        tick();
        pc_ld = 1'b0; rd_len = 2'd0; #1;
        chk("t2_flush_ok",   32'(dout_ok), 32'h0);
        chk("t2_flush_dout", dout,         32'h0);
        tick();
        chk("t2_bus_addr", 32'(bus_if.bus_addr), 32'h100);
        chk("t2_bus_rd",   32'(bus_if.bus_rd),   32'h1);
        tick();
        chk("t2_dout",   dout,         32'h00000034);
        chk("t2_head",   32'(head),    32'h101);
        chk("t2_ok1",    32'(dout_ok), 32'h1);
        rd_len = 2'd1; #1;
        chk("t2_ok2",    32'(dout_ok), 32'h0);

        // Stalled consumer: queue fills with exactly four word reads
        pc_ld = 1'b1; pc_new = 24'h000100; rd_len = 2'd3;
        tick();
        pc_ld = 1'b0;
        nreads = 0;
        repeat (20) begin
            tick();
            if (bus_if.bus_rd && bus_if.bus_ok) nreads++;
        end
        chk("t3_reads",   32'(nreads),          32'd4);
        chk("t3_full_rd", 32'(bus_if.bus_rd),   32'h0);
        chk("t3_ok",      32'(dout_ok),         32'h1);
        chk("t3_dout",    dout,                 32'h36143412);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t3_pop_head", 32'(head),           32'h104);
        chk("t3_pop_dout", dout,                32'h3A183816);
        chk("t3_pop_rd",   32'(bus_if.bus_rd),  32'h0);
        tick();
        chk("t3_refill_rd",   32'(bus_if.bus_rd),   32'h1);
        chk("t3_refill_addr", 32'(bus_if.bus_addr), 32'h108);
        tick();

        // Pop 3 of 6, then a 2-byte push and a 2-byte pop in one cycle
        rd = 1'b1; rd_len = 2'd2;
        tick();
        chk("t6_head3", 32'(head),             32'h107);
        chk("t6_addr",  32'(bus_if.bus_addr),  32'h10A);
        chk("t6_rd",    32'(bus_if.bus_rd),    32'h1);
        rd_len = 2'd1;
        tick();
        rd = 1'b0;
        chk("t6_head", 32'(head), 32'h109);
        rd_len = 2'd3; #1;
        chk("t6_ok4",  32'(dout_ok), 32'h0);
        chk("t6_dout", dout,         32'h003E1C3C);
        rd_len = 2'd2; #1;
        chk("t6_ok3",  32'(dout_ok), 32'h1);

        // pc_ld during an outstanding read: wait it out, discard, refetch
        lat = 5;
        tick();
        chk("t4_busrd", 32'(bus_if.bus_rd), 32'h1);
        pc_ld = 1'b1; pc_new = 24'h002000; rd_len = 2'd0;
        tick();
        pc_ld = 1'b0;
        chk("t4_hold_rd",   32'(bus_if.bus_rd),   32'h1);
        chk("t4_old_addr",  32'(bus_if.bus_addr), 32'h10C);
        chk("t4_head",      32'(head),            32'h2000);
        chk("t4_empty",     32'(dout_ok),         32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_drop_wait", {30'd0, bus_if.bus_rd, dout_ok}, 32'h2);
        end
        tick();
        chk("t4_drop_done", {30'd0, bus_if.bus_rd, dout_ok}, 32'h0);
        lat = 1;
        tick();
        chk("t4_new_addr", 32'(bus_if.bus_addr), 32'h2000);
        chk("t4_new_rd",   32'(bus_if.bus_rd),   32'h1);
        chk("t4_still_empty", 32'(dout_ok),      32'h0);
        tick();
        rd_len = 2'd1; #1;
        chk("t4_ok",   32'(dout_ok), 32'h1);
        chk("t4_dout", dout,         32'h00005331);

        // pc_ld in the same cycle as bus_ok: data discarded
        tick();
        chk("sc_ok_cycle", {30'd0, bus_if.bus_rd, bus_if.bus_ok}, 32'h3);
        pc_ld = 1'b1; pc_new = 24'h003000;
        tick();
        pc_ld = 1'b0; rd_len = 2'd0; #1;
        chk("sc_rd",   32'(bus_if.bus_rd), 32'h0);
        chk("sc_ok",   32'(dout_ok),       32'h0);
        chk("sc_head", 32'(head),          32'h3000);
        tick();
        chk("sc_addr", 32'(bus_if.bus_addr), 32'h3000);
        tick();
        chk("sc_dout", dout, 32'h00006341);

        // hold blocks new requests only
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_rd", 32'(bus_if.bus_rd), 32'h0);
        end
        mem_en = 1'b0; hold = 1'b0;
        tick();
        chk("t5_req_rd",   32'(bus_if.bus_rd),   32'h1);
        chk("t5_req_addr", 32'(bus_if.bus_addr), 32'h3002);

        // cen=0 freezes everything, including pc_ld and rd
        cen = 1'b0; rd = 1'b1; rd_len = 2'd0; pc_ld = 1'b1; pc_new = 24'h005555;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_frz_rd",   32'(bus_if.bus_rd),   32'h1);
            chk("t5_frz_addr", 32'(bus_if.bus_addr), 32'h3002);
            chk("t5_frz_head", 32'(head),            32'h3000);
            chk("t5_frz_dout", dout,                 32'h00006341);
            chk("t5_frz_ok",   32'(dout_ok),         32'h1);
        end
        cen = 1'b1; rd = 1'b0; pc_ld = 1'b0; mem_en = 1'b1;
        tick(); tick();
        chk("t5_resume_dout", dout,      32'h65436341);
        chk("t5_resume_head", 32'(head), 32'h3000);

        // Reset in the middle of a bus read; a late bus_ok is ignored
        mem_en = 1'b0;
        tick();
        chk("rr_busrd", 32'(bus_if.bus_rd), 32'h1);
        rst = 1'b1;
        tick();
        chk("rr_bus_rd",   32'(bus_if.bus_rd),   32'h0);
        chk("rr_bus_addr", 32'(bus_if.bus_addr), 32'h0);
        chk("rr_head",     32'(head),            32'h0);
        chk("rr_dout",     dout,                 32'h0);
        chk("rr_dout_ok",  32'(dout_ok),         32'h0);
        rst = 1'b0; stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("rr_late_rd",   32'(bus_if.bus_rd), 32'h0);
        chk("rr_late_ok",   32'(dout_ok),       32'h0);
        chk("rr_late_dout", dout,               32'h0);
        tick();
        chk("rr_stop_rd",   32'(bus_if.bus_rd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
